// File: rtl/dmem_arbiter.sv
// Round-robin arbiter multiplexing one data-memory port among num_cores_p cores.
// Optional watchdog timeout enabled by defining DMEM_ARB_TIMEOUT_EN.
package dmem_arbiter_pkg;

   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;

endpackage

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int num_cores_p = 4,
   parameter int timeout_p   = 255
) (
   input  logic                            clk,
   input  logic                            reset,
   input  mem_in_s                         core_req_i [num_cores_p],
   input  logic [num_cores_p-1:0][31:0]    core_addr_i,
   output mem_out_s                        core_resp_o [num_cores_p],
   output mem_in_s                         mem_req_o,
   output logic [31:0]                     mem_addr_o,
   input  mem_out_s                        mem_resp_i,
   output logic [$clog2(num_cores_p)-1:0]  grant_o,
   output logic                            busy_o,
   output logic                            error_o
);

   localparam int idx_w = $clog2(num_cores_p);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t           state;
   logic [idx_w-1:0] rr_ptr_r;
   logic [idx_w-1:0] grant_r;
   logic [idx_w-1:0] pick;
   logic [idx_w-1:0] cand;
   logic             found;
   logic             timeout_hit;

   function automatic logic [idx_w-1:0] wrap_inc(input logic [idx_w-1:0] x);
      return (x == idx_w'(num_cores_p - 1)) ? '0 : x + 1'b1;
   endfunction

   // First valid core at or after the round-robin pointer, wrapping modulo num_cores_p.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_r;
      cand  = '0;
      for (int i = 0; i < num_cores_p; i++) begin
         cand = idx_w'((int'(rr_ptr_r) + i) % num_cores_p);
         if (!found && core_req_i[cand].valid) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr_r <= '0;
         grant_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_r <= pick;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (mem_resp_i.yumi) begin
                  if (mem_resp_i.valid && core_req_i[grant_r].yumi) begin
                     state    <= IDLE;
                     rr_ptr_r <= wrap_inc(grant_r);
                  end else begin
                     state <= RESP;
                  end
               end else if (!core_req_i[grant_r].valid) begin
                  state <= IDLE;
               end
            end
            RESP: begin
               if (mem_resp_i.valid && core_req_i[grant_r].yumi) begin
                  state    <= IDLE;
                  rr_ptr_r <= wrap_inc(grant_r);
               end
            end
            default: state <= IDLE;
         endcase
         // A stuck transaction is abandoned and the offending core skipped.
         if (timeout_hit) begin
            state    <= IDLE;
            rr_ptr_r <= wrap_inc(grant_r);
         end
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int wd_w = ($clog2(timeout_p + 1) > 8) ? $clog2(timeout_p + 1) : 8;

   logic [wd_w-1:0] wd_r;
   logic            error_r;

   assign timeout_hit = (state != IDLE) && (wd_r == wd_w'(timeout_p - 1));
   assign error_o     = error_r;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_r    <= '0;
         error_r <= 1'b0;
      end else begin
         if (state == IDLE || timeout_hit) wd_r <= '0;
         else                              wd_r <= wd_r + 1'b1;
         if (timeout_hit) error_r <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign error_o     = 1'b0;
`endif

   // Handshake forwarding is purely combinational on the registered state.
   always_comb begin
      mem_req_o  = '0;
      mem_addr_o = '0;
      for (int k = 0; k < num_cores_p; k++) begin
         core_resp_o[k].read_data = mem_resp_i.read_data;
         core_resp_o[k].valid     = 1'b0;
         core_resp_o[k].yumi      = 1'b0;
      end
      case (state)
         REQ: begin
            mem_req_o                    = core_req_i[grant_r];
            mem_req_o.yumi               = 1'b0;
            mem_addr_o                   = core_addr_i[grant_r];
            core_resp_o[grant_r].yumi    = mem_resp_i.yumi;
            core_resp_o[grant_r].valid   = mem_resp_i.yumi & mem_resp_i.valid;
         end
         RESP: begin
            mem_req_o                    = core_req_i[grant_r];
            mem_req_o.valid              = 1'b0;
            mem_req_o.yumi               = core_req_i[grant_r].yumi;
            mem_addr_o                   = core_addr_i[grant_r];
            core_resp_o[grant_r].valid   = mem_resp_i.valid;
         end
         default: ;
      endcase
   end

   assign busy_o  = (state != IDLE);
   assign grant_o = grant_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter sharing one data memory port between `num_cores_p` cores. Each core connects its `to_mem_o`/`data_mem_addr`/`from_mem_i` unchanged. The arbiter serialises transactions: one outstanding request at a time. It forwards the valid/yumi handshake in both directions between the granted core and the memory.

## Interface
- `num_cores_p`, 4: number of requesting cores (2..16).
- `timeout_p`, 255: watchdog limit in cycles; used only with `DMEM_ARB_TIMEOUT_EN`.
- `clk`  input  1  clock, all state on rising edge.
- `reset`  input  1  synchronous, active-low reset; one clock, same edge as all state.
- `core_req_i`  input  `mem_in_s [num_cores_p]`  per-core request (`write_data`, `valid`, `wen`, `byte_not_word`, `yumi`).
- `core_addr_i`  input  `[num_cores_p][31:0]`  per-core byte address.
- `core_resp_o`  output  `mem_out_s [num_cores_p]`  per-core response (`read_data`, `valid`, `yumi`).
- `mem_req_o`  output  `mem_in_s`  request to data memory.
- `mem_addr_o`  output  32  address to data memory.
- `mem_resp_i`  input  `mem_out_s`  data memory response.
- `grant_o`  output  `$clog2(num_cores_p)`  index of the current/last granted core.
- `busy_o`  output  1  high when not IDLE.
- `error_o`  output  1  sticky watchdog error.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - Scan `core_req_i[k].valid` starting at `rr_ptr_r`, wrapping modulo `num_cores_p`.
  - The first valid core is latched into `grant_r`; next state is REQ.
  - If no core is valid, stay in IDLE.
  - Nothing is driven to memory in IDLE.
- **REQ**
  - `mem_req_o` = `core_req_i[grant_r]`, except `yumi` = 0.
  - `mem_addr_o` = `core_addr_i[grant_r]`.
  - `core_resp_o[grant_r].yumi` = `mem_resp_i.yumi`.
  - On `mem_resp_i.yumi`, go to RESP.
  - If the granted core's `valid` is low and `mem_resp_i.yumi` is low, go to IDLE; `rr_ptr_r` is unchanged (withdrawn request).
- **RESP**
  - `mem_req_o.valid` = 0.
  - `core_resp_o[grant_r].valid` = `mem_resp_i.valid`.
  - `mem_req_o.yumi` = `core_req_i[grant_r].yumi`.
  - When `mem_resp_i.valid && core_req_i[grant_r].yumi`, go to IDLE and set `rr_ptr_r` = `grant_r`+1 (wrap).
- **Same-cycle acceptance and response**
  - In REQ, if `mem_resp_i.yumi` and `mem_resp_i.valid` are both high, the response is forwarded in the same cycle.
  - If the core's `yumi` is also high, go directly to IDLE with the pointer advanced.
- **Response fields**
  - `read_data` is broadcast to all cores.
  - `valid` and `yumi` are 0 for every non-granted core, in every state.
- `busy_o` = (state != IDLE); `grant_o` = `grant_r`.

## Timing
- Reset values: state IDLE, `rr_ptr_r` 0, `grant_r` 0, `error_o` 0, watchdog 0.
- Outputs after reset: all `core_resp_o` valid/yumi 0, `mem_req_o.valid` 0, `mem_req_o.yumi` 0.
- Arbitration latency: a core valid in cycle N appears on `mem_req_o.valid` in cycle N+1, if IDLE in cycle N.
- Minimum transaction (memory yumi+valid and core yumi all in the first REQ cycle): 2 cycles; back-to-back grants every 2 cycles.
- All handshake forwarding is combinational within a state. Only `grant_r`, `rr_ptr_r`, the state and the watchdog are registered.
- Reset mid-transaction returns to IDLE next edge; the in-flight memory request is abandoned.
- Fairness: a continuously requesting core is granted within `num_cores_p` transactions.

## Configuration
- `DMEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit+ watchdog counts cycles spent in REQ or RESP and clears on entry to IDLE.
  - When the count reaches `timeout_p`:
    - `error_o` sets, and stays set until reset.
    - State forces to IDLE.
    - `rr_ptr_r` advances past `grant_r`.
- `DMEM_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `error_o` is tied 0.
  - REQ/RESP wait indefinitely.

## Test plan
- **Single request:** core 2 load, addr 0x40; memory gives yumi in cycle 2 and valid with data 0xDEADBEEF in cycle 4; core yumi in cycle 4.
  - Required: only core 2 sees yumi and valid, `read_data` 0xDEADBEEF, IDLE in cycle 5, `rr_ptr_r` = 3.
- **Round robin:** cores 0,1,3 request simultaneously from reset.
  - Required: grant order 0,1,3; then core 0 re-requesting is served after 3 and before 1.
- **Same-cycle handshake:** memory asserts yumi and valid together in the first REQ cycle, and the core yumis.
  - Required: transaction completes in 2 cycles; the next grant issues in the following cycle.
- **Response backpressure:** core delays yumi 3 cycles after memory valid.
  - Required: stays in RESP; `mem_req_o.yumi` is 0 until the core's yumi, then IDLE.
- **Withdrawal and reset:** core 1 drops valid in REQ before memory yumi.
  - Required: IDLE next cycle, pointer unchanged.
  - Separately, reset asserted in RESP: all outputs at reset values next cycle.
- **Timeout (`DMEM_ARB_TIMEOUT_EN`, `timeout_p`=8):** memory never yumis.
  - Required: `error_o` rises after 8 REQ cycles and stays 1; the next valid core is then granted.
